branch_sequencer: RTL and testbench
===================================

// Module: branch_sequencer
// PURPOSE
//  Program-flow controller for the 16-bit core: owns the PC and the carry flag, and runs fetch/execute/jump-evaluate.
//  Drives the jump-condition unit (registered carry, jump-control, condition value) and samples its i_cond to pick
//  the next PC (target or PC+1). Sits between instruction memory and the decode/execute datapath.
// PARAMETERS
//  ADDR_W    16       PC / instruction-address width
//  RESET_PC  16'h0000 PC value loaded on reset
// PORTS
//  i_clk            in   1       sole clock, rising edge
//  i_rst_n          in   1       asynchronous, active-low reset
//  o_imem_req       out  1       instruction fetch request
//  o_imem_addr      out  ADDR_W  fetch address (= PC)
//  i_imem_ack       in   1       fetch complete; i_imem_data valid this cycle
//  i_imem_data      in   16      fetched instruction word
//  o_instr          out  16      latched instruction to decode/execute
//  o_instr_valid    out  1       1-cycle pulse: o_instr is new
//  i_exec_done      in   1       execute of current instruction finished
//  i_carry_we       in   1       with i_exec_done: write carry flag
//  i_carry_in       in   1       new carry value
//  i_is_jump        in   1       with i_exec_done: instruction is a jump
//  i_jCtrl          in   6       jump control field of the instruction
//  i_jCondVal       in   16      register value tested by the jump
//  i_jump_target    in   ADDR_W  jump destination
//  o_carry          out  1       carry flag -> jump-condition unit
//  o_jCtrl          out  6       registered jump control -> jump-condition unit
//  o_jCondVal       out  16      registered condition value -> jump-condition unit
//  i_cond           in   1       jump-condition unit result (combinational from the three outputs above)
//  i_halt           in   1       stop request, sampled in FETCH only
//  o_halted         out  1       1 while in HALT
//  o_retired        out  16      count of retired instructions, wraps
// BEHAVIOUR
//  Reset (async assert, sync-released use): state=FETCH, PC=RESET_PC, o_carry=0, o_jCtrl=0, o_jCondVal=0,
//   o_instr=0, o_instr_valid=0, o_imem_req=0, o_halted=0, o_retired=0. Reset mid-fetch drops o_imem_req at once.
//  States: FETCH, WAIT, EXEC, JEVAL, HALT.
//  FETCH: i_halt=1 -> HALT; else -> WAIT with o_imem_req=1, o_imem_addr=PC.
//  WAIT: o_imem_req held 1, addr stable, until i_imem_ack. On ack: o_instr<=i_imem_data,
//   o_instr_valid pulses next cycle, o_imem_req=0 -> EXEC. Ack outside WAIT is ignored.
//  EXEC: wait for i_exec_done (may come the first EXEC cycle). On done:
//   - i_carry_we=1 -> o_carry<=i_carry_in (same edge);
//   - o_retired<=o_retired+1 (mod 2^16);
//   - i_is_jump=1 -> o_jCtrl<=i_jCtrl, o_jCondVal<=i_jCondVal, -> JEVAL;
//   - else PC<=PC+1 -> FETCH.
//  JEVAL (1 cycle): i_cond sampled against the registered values, including any carry written by the same done;
//   i_cond=1 -> PC<=i_jump_target, else PC<=PC+1; -> FETCH.
//  PC arithmetic modulo 2^ADDR_W: 16'hFFFF+1 = 16'h0000; a jump to the current PC is legal (tight loop).
//  HALT: absorbing; o_halted=1, o_imem_req=0; only reset leaves it. i_halt outside FETCH is ignored
//   (the current instruction completes first).
//  Latency, non-jump: FETCH(1)+WAIT(>=1)+EXEC(>=1) cycles; jump adds 1 (JEVAL).
//  o_jCtrl/o_jCondVal hold their last value outside JEVAL (no toggling for power).
// STRUCTURE
//  Shared package cpu_pkg: state enum localparams (FETCH..HALT), ADDR_W, RESET_PC default, JCTRL_W=6.
//  One natural sub-module: pc_unit (PC register, incrementer, target mux; load/inc controls from FSM).
//  The jump-condition unit stays external; this block only registers its inputs and reads i_cond.
// TESTING
//  1 Reset, ack 1 cycle after req, data 16'h1234, done w/o jump -> o_instr=16'h1234, addrs 0,1,2..., retired=1.
//  2 PC=16'hFFFF non-jump -> next o_imem_addr=16'h0000.
//  3 Jump, target 16'h0040, bench i_cond=1 -> next addr 16'h0040; same with i_cond=0 -> PC+1.
//  4 done with carry_we=1, carry_in=1, is_jump=1 -> o_carry=1 in JEVAL, before i_cond is sampled.
//  5 ack held off 5 cycles -> req/addr stable throughout; stray ack during EXEC ignored.
//  6 i_halt during EXEC -> instruction retires, HALT on the next FETCH; reset asserted in WAIT -> req=0 at once.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit core's program-flow control.
package cpu_pkg;

  localparam int          ADDR_W   = 16;
  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam int          JCTRL_W  = 6;
  localparam int          WORD_W   = 16;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    WAIT  = 3'd1,
    EXEC  = 3'd2,
    JEVAL = 3'd3,
    HALT  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/pc_unit.sv
// Program counter register with wrapping incrementer and jump-target mux.
module pc_unit #(
  parameter int                ADDR_W   = cpu_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc
);

  // A taken jump wins over the increment; the add wraps modulo 2^ADDR_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/branch_sequencer.sv
// Fetch/execute/jump-evaluate sequencer: owns the PC, the carry flag and the
// registered inputs of the external jump-condition unit.
module branch_sequencer
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = cpu_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  output logic               o_imem_req,
  output logic [ADDR_W-1:0]  o_imem_addr,
  input  logic               i_imem_ack,
  input  logic [WORD_W-1:0]  i_imem_data,
  output logic [WORD_W-1:0]  o_instr,
  output logic               o_instr_valid,
  input  logic               i_exec_done,
  input  logic               i_carry_we,
  input  logic               i_carry_in,
  input  logic               i_is_jump,
  input  logic [JCTRL_W-1:0] i_jCtrl,
  input  logic [WORD_W-1:0]  i_jCondVal,
  input  logic [ADDR_W-1:0]  i_jump_target,
  output logic               o_carry,
  output logic [JCTRL_W-1:0] o_jCtrl,
  output logic [WORD_W-1:0]  o_jCondVal,
  input  logic               i_cond,
  input  logic               i_halt,
  output logic               o_halted,
  output logic [WORD_W-1:0]  o_retired
);

  seq_state_t        state;
  logic              pc_load;
  logic              pc_inc;
  logic [ADDR_W-1:0] pc;

  // PC moves on a finished non-jump, or once the jump condition is known.
  always_comb begin
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    if (state == EXEC && i_exec_done && !i_is_jump) begin
      pc_inc = 1'b1;
    end
    if (state == JEVAL) begin
      pc_load = i_cond;
      pc_inc  = !i_cond;
    end
  end

  pc_unit #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .load   (pc_load),
    .inc    (pc_inc),
    .target (i_jump_target),
    .pc     (pc)
  );

  assign o_imem_addr = pc;

  // Main sequencer; all control outputs are registered here. The jump-condition
  // inputs are only written on a jumping done, so they hold otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= FETCH;
      o_imem_req    <= 1'b0;
      o_instr       <= '0;
      o_instr_valid <= 1'b0;
      o_carry       <= 1'b0;
      o_jCtrl       <= '0;
      o_jCondVal    <= '0;
      o_halted      <= 1'b0;
      o_retired     <= '0;
    end else begin
      o_instr_valid <= 1'b0;
      case (state)
        FETCH: begin
          if (i_halt) begin
            state      <= HALT;
            o_halted   <= 1'b1;
            o_imem_req <= 1'b0;
          end else begin
            state      <= WAIT;
            o_imem_req <= 1'b1;
          end
        end
        WAIT: begin
          if (i_imem_ack) begin
            o_instr       <= i_imem_data;
            o_instr_valid <= 1'b1;
            o_imem_req    <= 1'b0;
            state         <= EXEC;
          end
        end
        EXEC: begin
          if (i_exec_done) begin
            if (i_carry_we) begin
              o_carry <= i_carry_in;
            end
            o_retired <= o_retired + 1'b1;
            if (i_is_jump) begin
              o_jCtrl    <= i_jCtrl;
              o_jCondVal <= i_jCondVal;
              state      <= JEVAL;
            end else begin
              state <= FETCH;
            end
          end
        end
        JEVAL: begin
          state <= FETCH;
        end
        HALT: begin
          o_halted   <= 1'b1;
          o_imem_req <= 1'b0;
        end
        default: begin
          state      <= FETCH;
          o_imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed testbench for branch_sequencer. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_branch_sequencer;
  import cpu_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        o_imem_req;
  logic [15:0] o_imem_addr;
  logic        i_imem_ack;
  logic [15:0] i_imem_data;
  logic [15:0] o_instr;
  logic        o_instr_valid;
  logic        i_exec_done;
  logic        i_carry_we;
  logic        i_carry_in;
  logic        i_is_jump;
  logic [5:0]  i_jCtrl;
  logic [15:0] i_jCondVal;
  logic [15:0] i_jump_target;
  logic        o_carry;
  logic [5:0]  o_jCtrl;
  logic [15:0] o_jCondVal;
  logic        i_cond;
  logic        i_halt;
  logic        o_halted;
  logic [15:0] o_retired;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  branch_sequencer dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_ack    (i_imem_ack),
    .i_imem_data   (i_imem_data),
    .o_instr       (o_instr),
    .o_instr_valid (o_instr_valid),
    .i_exec_done   (i_exec_done),
    .i_carry_we    (i_carry_we),
    .i_carry_in    (i_carry_in),
    .i_is_jump     (i_is_jump),
    .i_jCtrl       (i_jCtrl),
    .i_jCondVal    (i_jCondVal),
    .i_jump_target (i_jump_target),
    .o_carry       (o_carry),
    .o_jCtrl       (o_jCtrl),
    .o_jCondVal    (o_jCondVal),
    .i_cond        (i_cond),
    .i_halt        (i_halt),
    .o_halted      (o_halted),
    .o_retired     (o_retired)
  );

  // Stimulus-only helpers (no checking inside).
  task automatic step();
    @(negedge i_clk);
  endtask

  task automatic ack_with(input logic [15:0] data);
    i_imem_ack  = 1'b1;
    i_imem_data = data;
    @(negedge i_clk);
    i_imem_ack  = 1'b0;
  endtask

  task automatic done_with(input logic jump, input logic we, input logic cin,
                           input logic [5:0] ctrl, input logic [15:0] val,
                           input logic [15:0] tgt);
    i_exec_done   = 1'b1;
    i_is_jump     = jump;
    i_carry_we    = we;
    i_carry_in    = cin;
    i_jCtrl       = ctrl;
    i_jCondVal    = val;
    i_jump_target = tgt;
    @(negedge i_clk);
    i_exec_done = 1'b0;
    i_is_jump   = 1'b0;
    i_carry_we  = 1'b0;
    i_carry_in  = 1'b0;
  endtask

  task automatic jeval_with(input logic cond);
    i_cond = cond;
    @(negedge i_clk);
    i_cond = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (2) step();
    checks++; if (o_imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got=%b exp=0", o_imem_req); end
    checks++; if (o_imem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL reset_addr got=%h exp=0000", o_imem_addr); end
    checks++; if (o_instr !== 16'h0000 || o_instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_instr got=%h/%b exp=0000/0", o_instr, o_instr_valid); end
    checks++; if (o_carry !== 1'b0 || o_jCtrl !== 6'h00 || o_jCondVal !== 16'h0000) begin errors++; $display("[TB] FAIL reset_jregs got=%b/%h/%h exp=0/00/0000", o_carry, o_jCtrl, o_jCondVal); end
    checks++; if (o_halted !== 1'b0 || o_retired !== 16'h0000) begin errors++; $display("[TB] FAIL reset_status got=%b/%h exp=0/0000", o_halted, o_retired); end
    i_rst_n = 1'b1;
  endtask

  task automatic test_basic_fetch();
    step();
    checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL basic_req0 got=%b/%h exp=1/0000", o_imem_req, o_imem_addr); end
    ack_with(16'h1234);
    checks++; if (o_instr !== 16'h1234 || o_instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_instr got=%h/%b exp=1234/1", o_instr, o_instr_valid); end
    checks++; if (o_imem_req !== 1'b0) begin errors++; $display("[TB] FAIL basic_req_drop got=%b exp=0", o_imem_req); end
    step();
    checks++; if (o_instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid_pulse got=%b exp=0", o_instr_valid); end
    done_with(1'b0, 1'b0, 1'b0, 6'h00, 16'h0000, 16'h0000);
    checks++; if (o_retired !== 16'd1) begin errors++; $display("[TB] FAIL basic_retired1 got=%0d exp=1", o_retired); end
    step();
    checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 16'h0001) begin errors++; $display("[TB] FAIL basic_addr1 got=%b/%h exp=1/0001", o_imem_req, o_imem_addr); end
    ack_with(16'h0000);
    done_with(1'b0, 1'b0, 1'b0, 6'h00, 16'h0000, 16'h0000);
    step();
    checks++; if (o_imem_addr !== 16'h0002 || o_retired !== 16'd2) begin errors++; $display("[TB] FAIL basic_addr2 got=%h/%0d exp=0002/2", o_imem_addr, o_retired); end
    ack_with(16'h0000);
    done_with(1'b0, 1'b0, 1'b0, 6'h00, 16'h0000, 16'h0000);
  endtask

  task automatic test_pc_wrap();
    step();
    checks++; if (o_imem_addr !== 16'h0003) begin errors++; $display("[TB] FAIL wrap_addr3 got=%h exp=0003", o_imem_addr); end
    ack_with(16'h0000);
    done_with(1'b1, 1'b0, 1'b0, 6'h00, 16'h0000, 16'hFFFF);
    jeval_with(1'b1);
    step();
    checks++; if (o_imem_addr !== 16'hFFFF) begin errors++; $display("[TB] FAIL wrap_addr_ffff got=%h exp=ffff", o_imem_addr); end
    ack_with(16'h0000);
    done_with(1'b0, 1'b0, 1'b0, 6'h00, 16'h0000, 16'h0000);
    step();
    checks++; if (o_imem_addr !== 16'h0000 || o_retired !== 16'd5) begin errors++; $display("[TB] FAIL wrap_addr_0 got=%h/%0d exp=0000/5", o_imem_addr, o_retired); end
  endtask

  task automatic test_jump();
    ack_with(16'h0000);
    done_with(1'b1, 1'b0, 1'b0, 6'h11, 16'h0F0F, 16'h0040);
    checks++; if (o_jCtrl !== 6'h11 || o_jCondVal !== 16'h0F0F || o_carry !== 1'b0) begin errors++; $display("[TB] FAIL jump_regs got=%h/%h/%b exp=11/0f0f/0", o_jCtrl, o_jCondVal, o_carry); end
    checks++; if (o_imem_req !== 1'b0) begin errors++; $display("[TB] FAIL jump_jeval_req got=%b exp=0", o_imem_req); end
    jeval_with(1'b1);
    step();
    checks++; if (o_imem_addr !== 16'h0040) begin errors++; $display("[TB] FAIL jump_taken got=%h exp=0040", o_imem_addr); end
    ack_with(16'h0000);
    done_with(1'b1, 1'b0, 1'b0, 6'h05, 16'h1111, 16'h0080);
    jeval_with(1'b0);
    step();
    checks++; if (o_imem_addr !== 16'h0041 || o_retired !== 16'd7) begin errors++; $display("[TB] FAIL jump_not_taken got=%h/%0d exp=0041/7", o_imem_addr, o_retired); end
  endtask

  task automatic test_carry_jump();
    ack_with(16'h0000);
    done_with(1'b1, 1'b1, 1'b1, 6'h2A, 16'hBEEF, 16'h0041);
    checks++; if (o_carry !== 1'b1) begin errors++; $display("[TB] FAIL carry_in_jeval got=%b exp=1", o_carry); end
    checks++; if (o_jCtrl !== 6'h2A || o_jCondVal !== 16'hBEEF) begin errors++; $display("[TB] FAIL carry_jregs got=%h/%h exp=2a/beef", o_jCtrl, o_jCondVal); end
    jeval_with(1'b1);
    step();
    checks++; if (o_imem_addr !== 16'h0041) begin errors++; $display("[TB] FAIL tight_loop got=%h exp=0041", o_imem_addr); end
    ack_with(16'h0000);
    done_with(1'b0, 1'b0, 1'b0, 6'h3F, 16'h5555, 16'h0000);
    checks++; if (o_carry !== 1'b1 || o_jCtrl !== 6'h2A || o_jCondVal !== 16'hBEEF) begin errors++; $display("[TB] FAIL jregs_hold got=%b/%h/%h exp=1/2a/beef", o_carry, o_jCtrl, o_jCondVal); end
  endtask

  task automatic test_ack_delay();
    int bad = 0;
    step();
    checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 16'h0042) begin errors++; $display("[TB] FAIL delay_req got=%b/%h exp=1/0042", o_imem_req, o_imem_addr); end
    for (int i = 0; i < 5; i++) begin
      step();
      if (o_imem_req !== 1'b1 || o_imem_addr !== 16'h0042 || o_instr_valid !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL delay_stable got=%0d unstable cycles exp=0", bad); end
    ack_with(16'hCAFE);
    checks++; if (o_instr !== 16'hCAFE || o_instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL delay_instr got=%h/%b exp=cafe/1", o_instr, o_instr_valid); end
    ack_with(16'hDEAD);
    checks++; if (o_instr !== 16'hCAFE || o_instr_valid !== 1'b0 || o_imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stray_ack got=%h/%b/%b exp=cafe/0/0", o_instr, o_instr_valid, o_imem_req); end
    done_with(1'b0, 1'b0, 1'b0, 6'h00, 16'h0000, 16'h0000);
    step();
    checks++; if (o_imem_addr !== 16'h0043 || o_retired !== 16'd10) begin errors++; $display("[TB] FAIL delay_next got=%h/%0d exp=0043/10", o_imem_addr, o_retired); end
  endtask

  task automatic test_halt();
    ack_with(16'h0000);
    i_halt = 1'b1;
    done_with(1'b0, 1'b0, 1'b0, 6'h00, 16'h0000, 16'h0000);
    checks++; if (o_retired !== 16'd11 || o_halted !== 1'b0) begin errors++; $display("[TB] FAIL halt_retire got=%0d/%b exp=11/0", o_retired, o_halted); end
    step();
    checks++; if (o_halted !== 1'b1 || o_imem_req !== 1'b0) begin errors++; $display("[TB] FAIL halt_enter got=%b/%b exp=1/0", o_halted, o_imem_req); end
    i_halt = 1'b0;
    repeat (3) step();
    checks++; if (o_halted !== 1'b1 || o_imem_req !== 1'b0 || o_imem_addr !== 16'h0044) begin errors++; $display("[TB] FAIL halt_absorb got=%b/%b/%h exp=1/0/0044", o_halted, o_imem_req, o_imem_addr); end
  endtask

  task automatic test_reset_in_wait();
    i_rst_n = 1'b0;
    step();
    checks++; if (o_halted !== 1'b0 || o_imem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL halt_reset got=%b/%h exp=0/0000", o_halted, o_imem_addr); end
    i_rst_n = 1'b1;
    step();
    step();
    checks++; if (o_imem_req !== 1'b1) begin errors++; $display("[TB] FAIL rst_wait_req got=%b exp=1", o_imem_req); end
    #2 i_rst_n = 1'b0;
    #1;
    checks++; if (o_imem_req !== 1'b0 || o_retired !== 16'd0) begin errors++; $display("[TB] FAIL rst_async got=%b/%0d exp=0/0", o_imem_req, o_retired); end
    step();
    i_rst_n = 1'b1;
  endtask

  initial begin
    i_rst_n       = 1'b0;
    i_imem_ack    = 1'b0;
    i_imem_data   = '0;
    i_exec_done   = 1'b0;
    i_carry_we    = 1'b0;
    i_carry_in    = 1'b0;
    i_is_jump     = 1'b0;
    i_jCtrl       = '0;
    i_jCondVal    = '0;
    i_jump_target = '0;
    i_cond        = 1'b0;
    i_halt        = 1'b0;
    test_reset();
    test_basic_fetch();
    test_pc_wrap();
    test_jump();
    test_carry_jump();
    test_ack_delay();
    test_halt();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
